uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver; the downstream consumer of the uart_tx serial line.
- Oversamples the line using the uart_baudgen x16 tick (o_baud_x16 / i_baud_x16_en pair) and majority-votes each bit.
- Delivers each received word as a single-cycle valid pulse, with frame-error and parity-error flags.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9), sent LSB first.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 even, 1 odd.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-high
- i_baud_x16  in  1  1-cycle tick at 16x baud rate, from uart_baudgen o_baud_x16
- o_baud_x16_en  out  1  enable to uart_baudgen i_baud_x16_en
- i_rx  in  1  asynchronous serial line, idle high
- o_dout  out  DATA_WIDTH  received word; holds until the next o_valid
- o_valid  out  1  1-cycle pulse, o_dout/flags valid
- o_frame_err  out  1  stop bit sampled low; qualified by o_valid
- o_parity_err  out  1  parity mismatch; qualified by o_valid
- o_busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (async, i_rst=1):
  - state IDLE, sync flops 1, all counters 0.
  - o_dout=0, o_valid=0, o_frame_err=0, o_parity_err=0, o_busy=0, o_baud_x16_en=0.
  - Reset mid-frame aborts the frame; no o_valid is produced for it.
- Synchroniser: 2-flop on i_rx -> rx_s; 2 clk latency. All decisions use rx_s.
- o_baud_x16_en = registered !i_rst; goes high 1 clk after reset release and stays high.
- All state/counter updates happen only on cycles with i_baud_x16=1; no other cycle changes state.
- Per-bit tick counter tcnt 0..15, reset to 0 on every bit boundary.
- Samples: rx_s captured at tcnt 7, 8, 9; bit value = majority of the 3 samples.
- States:
  - IDLE: tick with rx_s=0 -> START, tcnt=0.
  - START: at tcnt 15, if majority=1 -> IDLE (false start, no outputs); else -> DATA, bit index 0.
  - DATA: at tcnt 15, shift majority into shift reg MSB (right shift); after DATA_WIDTH bits -> PARITY if compiled in, else STOP.
  - PARITY: at tcnt 15, compute parity error; -> STOP.
  - STOP: decision at tcnt 9 (early, to allow resync to a back-to-back start bit). On that tick:
    - o_dout <= shift reg; o_valid <= 1 for one clk.
    - o_frame_err <= (majority==0).
    - If majority=1 -> IDLE; if 0 -> BREAK.
  - BREAK: wait for a tick with rx_s=1 -> IDLE. Prevents a held-low line (break) retriggering frames.
- No backpressure. A consumer that misses o_valid loses the word; o_dout is overwritten only at the next STOP decision.
- o_frame_err / o_parity_err hold their last value between pulses; only meaningful with o_valid.
- Minimum frame-to-frame gap accepted: start bit may begin 6 ticks after the stop decision.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state present; frame = start + DATA_WIDTH + parity + stop.
  - o_parity_err = (XOR of data bits XOR parity bit) != PARITY_ODD.
- Undefined:
  - PARITY state removed; DATA -> STOP directly.
  - o_parity_err tied 0.

Test Plan:
- Nominal: 25 MHz clk; baudgen divisor 13, frac adj 5 (x16 of 115200); drive frames 0xA6, 0x37, 0x00, 0xFF via model TX -> four o_valid pulses with matching o_dout, o_frame_err=0.
- Back-to-back: 0x55 then 0xAA with zero idle bits -> both received, exactly 2 o_valid pulses.
- Glitch rejection:
  - i_rx low for 3 x16 ticks from idle -> no o_valid, o_busy returns 0 by tick 16.
  - A 1-tick inverted glitch at tcnt 8 of data bit 3 of 0x0F -> o_dout=0x0F.
- Frame error / break: send 0x3C with stop bit low, then hold i_rx low 40 bit-times, then release -> one o_valid with o_dout=0x3C and o_frame_err=1; no further o_valid until a new frame; next frame 0x81 received cleanly.
- Reset mid-frame: assert i_rst during data bit 4 -> all outputs to reset values within the same cycle; no o_valid; next frame 0xC3 received correctly.
- UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 1 -> o_parity_err=0; with parity bit 0 -> o_parity_err=1; o_dout=0x07 both times.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver fed by the uart_baudgen x16 tick.
// Each bit is sampled at ticks 7, 8 and 9 of its 16-tick window and
// majority-voted. A received word is presented as a one-cycle o_valid pulse
// together with frame- and parity-error flags.
// Optional feature: define UART_RX_PARITY_EN to receive a parity bit between
// the data bits and the stop bit (sense chosen by PARITY_ODD). Without the
// macro the parity state is absent and o_parity_err is tied low.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_baud_x16,
    output logic                  o_baud_x16_en,
    input  logic                  i_rx,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_valid,
    output logic                  o_frame_err,
    output logic                  o_parity_err,
    output logic                  o_busy
);

    localparam int BIDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              sync_reg;
    logic                    rx_s;
    logic                    baud_en_reg;
    logic [3:0]              tcnt_reg, tcnt_next;
    logic [BIDX_W-1:0]       bidx_reg, bidx_next;
    logic [2:0]              samp_reg, samp_next;
    logic [DATA_WIDTH-1:0]   data_sr_reg, data_sr_next;
    logic [DATA_WIDTH-1:0]   dout_reg, dout_next;
    logic                    valid_reg, valid_next;
    logic                    frame_err_reg, frame_err_next;
    logic                    s9_eff;
    logic                    maj;
    logic                    stop_decide;
`ifdef UART_RX_PARITY_EN
    logic                    parity_bad_reg, parity_bad_next;
    logic                    parity_err_reg, parity_err_next;
`endif

    assign rx_s = sync_reg[1];

    // The stop decision happens on the tcnt-9 tick itself, so the third
    // sample is taken straight from the line on that tick.
    assign s9_eff = (tcnt_reg == 4'd9) ? rx_s : samp_reg[2];
    assign maj    = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & s9_eff) |
                    (samp_reg[1] & s9_eff);
    assign stop_decide = i_baud_x16 && (state_reg == S_STOP) && (tcnt_reg == 4'd9);

    // State register, synchroniser, counters and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= S_IDLE;
            sync_reg      <= 2'b11;
            baud_en_reg   <= 1'b0;
            tcnt_reg      <= '0;
            bidx_reg      <= '0;
            samp_reg      <= '0;
            data_sr_reg   <= '0;
            dout_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            sync_reg      <= {sync_reg[0], i_rx};
            baud_en_reg   <= 1'b1;
            tcnt_reg      <= tcnt_next;
            bidx_reg      <= bidx_next;
            samp_reg      <= samp_next;
            data_sr_reg   <= data_sr_next;
            dout_reg      <= dout_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= parity_bad_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    // Next-state logic; nothing moves except on a baud tick.
    always_comb begin
        state_next   = state_reg;
        tcnt_next    = tcnt_reg;
        bidx_next    = bidx_reg;
        samp_next    = samp_reg;
        data_sr_next = data_sr_reg;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad_reg;
`endif
        if (i_baud_x16) begin
            tcnt_next = tcnt_reg + 4'd1;
            if (tcnt_reg == 4'd7) samp_next[0] = rx_s;
            if (tcnt_reg == 4'd8) samp_next[1] = rx_s;
            if (tcnt_reg == 4'd9) samp_next[2] = rx_s;
            case (state_reg)
                S_IDLE: begin
                    tcnt_next = '0;
                    if (!rx_s) state_next = S_START;
                end
                S_START: begin
                    if (tcnt_reg == 4'd15) begin
                        bidx_next  = '0;
                        state_next = maj ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tcnt_reg == 4'd15) begin
                        data_sr_next = {maj, data_sr_reg[DATA_WIDTH-1:1]};
                        if (bidx_reg == BIDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_next = S_PARITY;
`else
                            state_next = S_STOP;
`endif
                        end else begin
                            bidx_next = bidx_reg + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tcnt_reg == 4'd15) begin
                        parity_bad_next = ((^data_sr_reg) ^ maj) != PARITY_ODD;
                        state_next      = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Decide early so a back-to-back start edge is not missed.
                    if (tcnt_reg == 4'd9) begin
                        tcnt_next  = '0;
                        state_next = maj ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    tcnt_next = '0;
                    if (rx_s) state_next = S_IDLE;
                end
                default: begin
                    tcnt_next  = '0;
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Output logic: publish the word and flags at the stop decision.
    always_comb begin
        dout_next      = dout_reg;
        valid_next     = 1'b0;
        frame_err_next = frame_err_reg;
`ifdef UART_RX_PARITY_EN
        parity_err_next = parity_err_reg;
`endif
        if (stop_decide) begin
            dout_next      = data_sr_reg;
            valid_next     = 1'b1;
            frame_err_next = ~maj;
`ifdef UART_RX_PARITY_EN
            parity_err_next = parity_bad_reg;
`endif
        end
    end

    assign o_baud_x16_en = baud_en_reg;
    assign o_dout        = dout_reg;
    assign o_valid       = valid_reg;
    assign o_frame_err   = frame_err_reg;
    assign o_busy        = (state_reg != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err  = parity_err_reg;
`else
    assign o_parity_err  = 1'b0;
`endif

endmodule
